// File: rtl/pipe_mem_stage.sv
// Memory-access stage with MEM/WB pipeline register: sized loads/stores over a
// req/ack data-memory handshake with timeout, stalling upstream while busy.
module pipe_mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [31:0]       ex_aluc,
  input  logic [31:0]       ex_rt_data,
  input  logic [31:0]       ex_pc4,
  input  logic              ex_RF_W_ena,
  input  logic [4:0]        ex_RF_waddr,
  input  logic [2:0]        ex_RF_mux_select,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_sign,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_aluc,
  output logic [31:0]       wb_dmem_out,
  output logic [31:0]       wb_pc4,
  output logic              wb_RF_W_ena,
  output logic [4:0]        wb_RF_waddr,
  output logic [2:0]        wb_RF_mux_select,
  output logic              align_err,
  output logic              bus_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam int unsigned   CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  logic [31:0] lat_aluc, lat_pc4, lat_wdata;
  logic [3:0]  lat_be;
  logic [1:0]  lat_size;
  logic        lat_sign, lat_wr, lat_rfw;
  logic [4:0]  lat_waddr;
  logic [2:0]  lat_sel;

  logic        memop, misalign, access;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, load_data;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign memop    = ex_valid & (ex_mem_rd | ex_mem_wr);
  assign misalign = ((ex_mem_size == 2'b01) & ex_aluc[0]) |
                    (ex_mem_size[1] & (ex_aluc[1:0] != 2'b00));
  assign access   = (state == ACCESS);

  // Lane placement is computed from ex_* and latched, so the bus stays stable.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ex_rt_data;
    case (ex_mem_size)
      2'b00: begin
        st_be    = 4'b0001 << ex_aluc[1:0];
        st_wdata = {4{ex_rt_data[7:0]}};
      end
      2'b01: begin
        st_be    = ex_aluc[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_rt_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v    = 8'(dmem_rdata >> {lat_aluc[1:0], 3'b000});
    half_v    = lat_aluc[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (lat_size)
      2'b00:   load_data = lat_sign ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      2'b01:   load_data = lat_sign ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: ;
    endcase
    if (lat_wr) load_data = '0;
  end

  assign dmem_req   = access;
  assign dmem_we    = access & lat_wr;
  assign dmem_addr  = access ? {lat_aluc[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = access ? lat_be : '0;
  assign dmem_wdata = access ? lat_wdata : '0;
  assign mem_stall  = !rst && (access ? (!dmem_ack && (cnt != LAST))
                                      : (memop && !misalign));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      lat_aluc         <= '0;
      lat_pc4          <= '0;
      lat_wdata        <= '0;
      lat_be           <= '0;
      lat_size         <= '0;
      lat_sign         <= 1'b0;
      lat_wr           <= 1'b0;
      lat_rfw          <= 1'b0;
      lat_waddr        <= '0;
      lat_sel          <= '0;
      wb_valid         <= 1'b0;
      wb_aluc          <= '0;
      wb_dmem_out      <= '0;
      wb_pc4           <= '0;
      wb_RF_W_ena      <= 1'b0;
      wb_RF_waddr      <= '0;
      wb_RF_mux_select <= '0;
      align_err        <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (memop && !misalign) begin
            state       <= ACCESS;
            cnt         <= '0;
            lat_aluc    <= ex_aluc;
            lat_pc4     <= ex_pc4;
            lat_wdata   <= st_wdata;
            lat_be      <= st_be;
            lat_size    <= ex_mem_size;
            lat_sign    <= ex_mem_sign;
            lat_wr      <= ex_mem_wr;
            lat_rfw     <= ex_RF_W_ena;
            lat_waddr   <= ex_RF_waddr;
            lat_sel     <= ex_RF_mux_select;
            wb_valid    <= 1'b0;
            wb_RF_W_ena <= 1'b0;
          end else begin
            wb_valid         <= ex_valid;
            wb_aluc          <= ex_aluc;
            wb_dmem_out      <= '0;
            wb_pc4           <= ex_pc4;
            wb_RF_waddr      <= ex_RF_waddr;
            wb_RF_mux_select <= ex_RF_mux_select;
            wb_RF_W_ena      <= ex_RF_W_ena & ex_valid & !memop;
            align_err        <= memop;
          end
        end
        ACCESS: begin
          if (dmem_ack || cnt == LAST) begin
            state            <= IDLE;
            wb_valid         <= 1'b1;
            wb_aluc          <= lat_aluc;
            wb_pc4           <= lat_pc4;
            wb_RF_waddr      <= lat_waddr;
            wb_RF_mux_select <= lat_sel;
            wb_dmem_out      <= dmem_ack ? load_data : '0;
            wb_RF_W_ena      <= dmem_ack & lat_rfw;
            bus_err          <= !dmem_ack;
          end else begin
            cnt         <= cnt + 1'b1;
            wb_valid    <= 1'b0;
            wb_RF_W_ena <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: ALU pass-through, sized loads/stores,
// misalignment, timeout, late ack and mid-access reset.
module tb_pipe_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_aluc, ex_rt_data, ex_pc4;
  logic        ex_RF_W_ena;
  logic [4:0]  ex_RF_waddr;
  logic [2:0]  ex_RF_mux_select;
  logic        ex_mem_rd, ex_mem_wr;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_sign;
  logic        mem_stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_aluc, wb_dmem_out, wb_pc4;
  logic        wb_RF_W_ena;
  logic [4:0]  wb_RF_waddr;
  logic [2:0]  wb_RF_mux_select;
  logic        align_err, bus_err;

  pipe_mem_stage #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_aluc(ex_aluc), .ex_rt_data(ex_rt_data), .ex_pc4(ex_pc4),
    .ex_RF_W_ena(ex_RF_W_ena), .ex_RF_waddr(ex_RF_waddr), .ex_RF_mux_select(ex_RF_mux_select),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_size(ex_mem_size), .ex_mem_sign(ex_mem_sign),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_aluc(wb_aluc), .wb_dmem_out(wb_dmem_out), .wb_pc4(wb_pc4),
    .wb_RF_W_ena(wb_RF_W_ena), .wb_RF_waddr(wb_RF_waddr), .wb_RF_mux_select(wb_RF_mux_select),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int          stall_n, req_n;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  task automatic drive(input logic [31:0] aluc, input logic [31:0] rt, input logic rd,
                       input logic wr, input logic [1:0] size, input logic sign,
                       input logic rfw, input logic [2:0] sel, input logic [4:0] waddr);
    ex_valid         = 1'b1;
    ex_aluc          = aluc;
    ex_rt_data       = rt;
    ex_pc4           = aluc + 32'd4;
    ex_mem_rd        = rd;
    ex_mem_wr        = wr;
    ex_mem_size      = size;
    ex_mem_sign      = sign;
    ex_RF_W_ena      = rfw;
    ex_RF_mux_select = sel;
    ex_RF_waddr      = waddr;
  endtask

  // Holds ex_* while stalled; acks on the ack_at-th request cycle (0 = never).
  task automatic run_mem(input int ack_at);
    bit done;
    done    = 1'b0;
    stall_n = 0;
    req_n   = 0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dmem_req) req_n++;
      dmem_ack = (ack_at != 0) && dmem_req && (req_n == ack_at);
      #1;
      if (dmem_req) begin
        cap_addr  = dmem_addr;
        cap_wdata = dmem_wdata;
        cap_be    = dmem_be;
        cap_we    = dmem_we;
      end
      if (mem_stall) stall_n++;
      else done = 1'b1;
      step();
      dmem_ack = 1'b0;
    end
    check("bound", 32'(done), 32'd1);
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    ex_valid = 1'b0; ex_aluc = '0; ex_rt_data = '0; ex_pc4 = '0;
    ex_RF_W_ena = 1'b0; ex_RF_waddr = '0; ex_RF_mux_select = '0;
    ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_mem_size = '0; ex_mem_sign = 1'b0;
    #3;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_wbvalid", 32'(wb_valid), 32'd0);
    check("rst_wbaluc", wb_aluc, 32'd0);
    step();
    rst = 1'b0;

    // ALU op pass-through
    drive(32'h1234, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'd5, 5'd5);
    #1;
    check("alu_stall", 32'(mem_stall), 32'd0);
    step();
    check("alu_valid", 32'(wb_valid), 32'd1);
    check("alu_aluc", wb_aluc, 32'h1234);
    check("alu_pc4", wb_pc4, 32'h1238);
    check("alu_rfw", 32'(wb_RF_W_ena), 32'd1);
    check("alu_waddr", 32'(wb_RF_waddr), 32'd5);
    check("alu_sel", 32'(wb_RF_mux_select), 32'd5);
    check("alu_req", 32'(dmem_req), 32'd0);
    ex_valid = 1'b0;
    step();
    check("bubble_valid", 32'(wb_valid), 32'd0);
    check("bubble_rfw", 32'(wb_RF_W_ena), 32'd0);

    // lb / lbu at lane 2
    dmem_rdata = 32'h80FF1234;
    drive(32'h102, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 3'd4, 5'd7);
    run_mem(1);
    check("lb_stall", 32'(stall_n), 32'd1);
    check("lb_req", 32'(req_n), 32'd1);
    check("lb_addr", cap_addr, 32'h100);
    check("lb_we", 32'(cap_we), 32'd0);
    check("lb_valid", 32'(wb_valid), 32'd1);
    check("lb_data", wb_dmem_out, 32'hFFFFFFFF);
    check("lb_aluc", wb_aluc, 32'h102);
    check("lb_rfw", 32'(wb_RF_W_ena), 32'd1);
    check("lb_waddr", 32'(wb_RF_waddr), 32'd7);
    check("lb_reqdrop", 32'(dmem_req), 32'd0);
    drive(32'h102, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'd4, 5'd7);
    run_mem(1);
    check("lbu_data", wb_dmem_out, 32'h000000FF);

    // lh signed, upper half
    dmem_rdata = 32'h80017FFF;
    drive(32'h2, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 3'd4, 5'd8);
    run_mem(1);
    check("lh_data", wb_dmem_out, 32'hFFFF8001);

    // sh with ack on 4th access cycle
    dmem_rdata = 32'h0;
    drive(32'h206, 32'h0000ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 3'd0, 5'd0);
    run_mem(4);
    check("sh_stall", 32'(stall_n), 32'd4);
    check("sh_addr", cap_addr, 32'h204);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);
    check("sh_we", 32'(cap_we), 32'd1);
    check("sh_valid", 32'(wb_valid), 32'd1);
    check("sh_rfw", 32'(wb_RF_W_ena), 32'd0);
    check("sh_dout", wb_dmem_out, 32'h0);

    // sb lane 3
    drive(32'h203, 32'h0000005A, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3'd0, 5'd0);
    run_mem(1);
    check("sb_be", 32'(cap_be), 32'h8);
    check("sb_wdata", cap_wdata, 32'h5A5A5A5A);

    // misaligned lw
    drive(32'h301, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 3'd4, 5'd9);
    run_mem(1);
    check("mis_req", 32'(req_n), 32'd0);
    check("mis_stall", 32'(stall_n), 32'd0);
    check("mis_align", 32'(align_err), 32'd1);
    check("mis_valid", 32'(wb_valid), 32'd1);
    check("mis_rfw", 32'(wb_RF_W_ena), 32'd0);
    step();
    check("mis_pulse", 32'(align_err), 32'd0);

    // timeout, then ALU op
    drive(32'h300, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 3'd4, 5'd10);
    run_mem(0);
    check("to_req", 32'(req_n), 32'd16);
    check("to_stall", 32'(stall_n), 32'd16);
    check("to_buserr", 32'(bus_err), 32'd1);
    check("to_valid", 32'(wb_valid), 32'd1);
    check("to_rfw", 32'(wb_RF_W_ena), 32'd0);
    check("to_idle", 32'(dmem_req), 32'd0);
    drive(32'h55, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 3'd5, 5'd3);
    step();
    ex_valid = 1'b0;
    check("to_pulse", 32'(bus_err), 32'd0);
    check("to_alu_aluc", wb_aluc, 32'h55);
    check("to_alu_rfw", 32'(wb_RF_W_ena), 32'd1);

    // ack on the timeout cycle wins
    dmem_rdata = 32'hCAFEF00D;
    drive(32'h304, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 3'd4, 5'd11);
    run_mem(16);
    check("late_req", 32'(req_n), 32'd16);
    check("late_buserr", 32'(bus_err), 32'd0);
    check("late_data", wb_dmem_out, 32'hCAFEF00D);
    check("late_rfw", 32'(wb_RF_W_ena), 32'd1);

    // reset mid-access
    step();
    drive(32'h400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 3'd4, 5'd12);
    step();
    step();
    check("rst_pre_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_req", 32'(dmem_req), 32'd0);
    check("rstmid_stall", 32'(mem_stall), 32'd0);
    check("rstmid_aluc", wb_aluc, 32'd0);
    check("rstmid_valid", 32'(wb_valid), 32'd0);
    ex_valid = 1'b0;
    step();
    rst = 1'b0;
    dmem_rdata = 32'hDEADBEEF;
    drive(32'h400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 3'd4, 5'd12);
    run_mem(2);
    check("post_stall", 32'(stall_n), 32'd2);
    check("post_data", wb_dmem_out, 32'hDEADBEEF);
    check("post_aluc", wb_aluc, 32'h400);
    check("post_valid", 32'(wb_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
